// File: rtl/uart_tx_arbiter.sv
// Two-source round-robin byte arbiter feeding a small FIFO that is drained into a UART transmitter.
// Optional burst lock is compiled in when UART_TX_ARB_LOCK_EN is defined.
module uart_tx_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [7:0]    req0_data,
    input  logic          req0_last,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [7:0]    req1_data,
    input  logic          req1_last,
    output logic          req1_ready,
    input  logic          uart_tx_busy,
    output logic          uart_tx_en,
    output logic [7:0]    uart_tx_data,
    output logic [LW-1:0] fifo_level,
    output logic          last_grant
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_ONE = LW'(1'b1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [LW-1:0] level_r, level_nxt_s;
    logic          full_r, prio_r, grant_r;
    logic          wait_cnt_r, wait_cnt_nxt_s;
    logic          en_r;
    logic [7:0]    data_r;
    logic          ready0_s, ready1_s, push_s, pop_s, launch_s;
    logic          grant_idx_s, push_last_s;
    logic [7:0]    push_data_s;

`ifdef UART_TX_ARB_LOCK_EN
    logic          lock_r, lock_owner_r;
`else
    logic          unused_last_s;
    assign unused_last_s = req0_last ^ req1_last;
`endif

    // Ready generation: full blocks both, lock pins the owner, ties go to the non-priority requester.
    always_comb begin
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        if (full_r) begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
        end
`ifdef UART_TX_ARB_LOCK_EN
        else if (lock_r) begin
            ready0_s = req0_valid & ~lock_owner_r;
            ready1_s = req1_valid &  lock_owner_r;
        end
`endif
        else if (req0_valid && req1_valid) begin
            ready0_s = prio_r;
            ready1_s = ~prio_r;
        end else begin
            ready0_s = req0_valid;
            ready1_s = req1_valid;
        end
    end

    assign req0_ready  = ready0_s;
    assign req1_ready  = ready1_s;
    assign push_s      = ready0_s | ready1_s;
    assign grant_idx_s = ready1_s;
    assign push_data_s = ready1_s ? req1_data : req0_data;
    assign push_last_s = ready1_s ? req1_last : req0_last;
    assign pop_s       = launch_s;

    // Issue FSM next-state: launch from IDLE, wait up to two cycles for busy, then wait for completion.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = 1'b0;
        launch_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if ((level_r != {LW{1'b0}}) && !uart_tx_busy) begin
                    state_nxt_s = WAIT_BUSY;
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_nxt_s = WAIT_DONE;
                end else if (wait_cnt_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s    = WAIT_BUSY;
                    wait_cnt_nxt_s = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Occupancy next value; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_nxt_s = level_r;
        if (push_s && !pop_s) begin
            level_nxt_s = level_r + LVL_ONE;
        end else if (pop_s && !push_s) begin
            level_nxt_s = level_r - LVL_ONE;
        end else begin
            level_nxt_s = level_r;
        end
    end

    // FSM state and busy-timeout register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            wait_cnt_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // FIFO pointers, level and registered full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            full_r   <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            level_r <= level_nxt_s;
            full_r  <= (level_nxt_s == DEPTH_L);
        end
    end

    // FIFO storage; contents need no reset since the level gates every read.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= push_data_s;
    end

    // Grant history: priority pointer starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r  <= 1'b1;
            grant_r <= 1'b0;
        end else if (push_s) begin
            prio_r  <= grant_idx_s;
            grant_r <= grant_idx_s;
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    // Burst lock: a non-last byte locks to its requester, a last byte from the owner releases it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_r       <= 1'b0;
            lock_owner_r <= 1'b0;
        end else if (push_s) begin
            lock_r       <= ~push_last_s;
            lock_owner_r <= grant_idx_s;
        end
    end
`endif

    // Launch pulse and head byte toward the transmitter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_r   <= 1'b0;
            data_r <= 8'h00;
        end else begin
            en_r <= launch_s;
            if (launch_s) data_r <= mem_r[rd_ptr_r];
        end
    end

    assign uart_tx_en   = en_r;
    assign uart_tx_data = data_r;
    assign fifo_level   = level_r;
    assign last_grant   = grant_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_uart_tx_arbiter;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_last, req0_ready;
    logic [7:0]    req0_data;
    logic          req1_valid, req1_last, req1_ready;
    logic [7:0]    req1_data;
    logic          uart_tx_busy, uart_tx_en;
    logic [7:0]    uart_tx_data;
    logic [LW-1:0] fifo_level;
    logic          last_grant;

    uart_tx_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .uart_tx_busy(uart_tx_busy), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
        .fifo_level(fifo_level), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] q[$];
    logic [7:0] out_log[$];
    logic       m_prio, m_last, m_lock, m_owner, prev_en;
    int         tx_left, busy_max;
    bit         hold_busy, never_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        out_log.delete();
        m_prio = 1'b1; m_last = 1'b0; m_lock = 1'b0; m_owner = 1'b0;
        prev_en = 1'b0; tx_left = 0;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0; req1_valid = 1'b0; req0_last = 1'b0; req1_last = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        uart_tx_busy = 1'b0; hold_busy = 1'b0; never_busy = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_en", 32'(uart_tx_en), 32'd0);
        chk("rst_data", 32'(uart_tx_data), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_grant", 32'(last_grant), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus; acc returns the index accepted by the model, or -1.
    task automatic cycle(input logic v0, input logic [7:0] d0, input logic l0,
                         input logic v1, input logic [7:0] d1, input logic l1, output int acc);
        logic e0, e1;
        int   size_before;
        req0_valid = v0; req0_data = d0; req0_last = l0;
        req1_valid = v1; req1_data = d1; req1_last = l1;
        #1;
        e0 = 1'b0; e1 = 1'b0;
        if (q.size() < DEPTH) begin
            if (m_lock) begin
                e0 = v0 && !m_owner;
                e1 = v1 && m_owner;
            end else if (v0 && v1) begin
                e0 = (m_prio != 1'b0);
                e1 = (m_prio == 1'b0);
            end else begin
                e0 = v0;
                e1 = v1;
            end
        end
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        size_before = q.size();
        @(posedge clk);
        #1;
        acc = -1;
        if (e0 || e1) begin
            acc = e1 ? 1 : 0;
            q.push_back(e1 ? d1 : d0);
            m_prio = e1;
            m_last = e1;
`ifdef UART_TX_ARB_LOCK_EN
            m_lock  = !(e1 ? l1 : l0);
            m_owner = e1;
`endif
        end
        if (uart_tx_en === 1'b1) begin
            chk("en_nonempty", 32'(size_before > 0), 32'd1);
            chk("en_width", 32'(prev_en), 32'd0);
            if (q.size() > 0) begin
                chk("tx_data", 32'(uart_tx_data), 32'(q[0]));
                out_log.push_back(uart_tx_data);
                void'(q.pop_front());
            end
        end
        prev_en = uart_tx_en;
        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("last_grant", 32'(last_grant), 32'(m_last));
        if (hold_busy) begin
            uart_tx_busy = 1'b1;
        end else if (never_busy) begin
            uart_tx_busy = 1'b0;
        end else begin
            if (tx_left > 0) begin
                uart_tx_busy = 1'b1;
                tx_left--;
            end else begin
                uart_tx_busy = 1'b0;
            end
            if (uart_tx_en === 1'b1) tx_left = $urandom_range(1, busy_max);
        end
    endtask

    task automatic idle_cycles(input int n);
        int acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, acc);
    endtask

    task automatic drain(input string tag);
        int acc;
        for (int i = 0; i < 200 && q.size() > 0; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, acc);
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc, a_idx, b_idx, n5;
        logic [7:0]  d5;
        logic        v0, v1;
        rst_n = 1'b0;
        busy_max = 3;
        do_reset();

        // Single byte: accepted, pulse two edges later, level 0->1->0.
        cycle(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, acc);
        chk("single_acc", 32'(acc), 32'd0);
        chk("single_en_early", 32'(uart_tx_en), 32'd0);
        chk("single_lvl1", 32'(fifo_level), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, acc);
        chk("single_en", 32'(uart_tx_en), 32'd1);
        chk("single_data", 32'(uart_tx_data), 32'h41);
        chk("single_lvl0", 32'(fifo_level), 32'd0);
        idle_cycles(6);

        // Contention: both valid continuously, strict alternation from req0.
        do_reset();
        a_idx = 0; b_idx = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 8'(8'hA0 + a_idx), 1'b0, 1'b1, 8'(8'hB0 + b_idx), 1'b0, acc);
            if (acc == 0) a_idx++;
            if (acc == 1) b_idx++;
        end
        drain("contend_drain");
        chk("contend_o0", 32'(out_log[0]), 32'hA0);
        chk("contend_o1", 32'(out_log[1]), 32'hB0);
        chk("contend_o2", 32'(out_log[2]), 32'hA1);
        chk("contend_o3", 32'(out_log[3]), 32'hB1);

        // Full: busy held, five pushes, fifth waits for the first pop.
        do_reset();
        hold_busy = 1'b1; uart_tx_busy = 1'b1;
        n5 = 0;
        for (int i = 0; i < 5; i++) begin
            d5 = 8'(8'h50 + n5);
            cycle(1'b1, d5, 1'b0, 1'b0, 8'h00, 1'b0, acc);
            if (acc == 0) n5++;
        end
        chk("full_accepted", 32'(n5), 32'd4);
        chk("full_ready0", 32'(req0_ready), 32'd0);
        hold_busy = 1'b0; uart_tx_busy = 1'b0;
        for (int i = 0; i < 20 && n5 < 5; i++) begin
            cycle(1'b1, 8'h54, 1'b0, 1'b0, 8'h00, 1'b0, acc);
            if (acc == 0) n5++;
        end
        chk("full_fifth", 32'(n5), 32'd5);
        drain("full_drain");
        chk("full_out_count", 32'(out_log.size()), 32'd5);

        // Busy never rises: timeout returns to IDLE and the next byte still launches.
        do_reset();
        never_busy = 1'b1;
        cycle(1'b1, 8'h61, 1'b0, 1'b0, 8'h00, 1'b0, acc);
        cycle(1'b1, 8'h62, 1'b0, 1'b0, 8'h00, 1'b0, acc);
        drain("timeout_drain");
        chk("timeout_count", 32'(out_log.size()), 32'd2);
        idle_cycles(4);

        // Reset mid-transfer with level 3 while the transmitter is busy.
        do_reset();
        busy_max = 30;
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 8'h00, 1'b0, acc);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, acc);
        chk("mid_level3", 32'(fifo_level), 32'd3);
        chk("mid_busy", 32'(uart_tx_busy), 32'd1);
        do_reset();
        busy_max = 3;
        cycle(1'b1, 8'h21, 1'b0, 1'b1, 8'h22, 1'b0, acc);
        chk("post_reset_tie", 32'(acc), 32'd0);
        drain("post_reset_drain");

`ifdef UART_TX_ARB_LOCK_EN
        // Burst lock: req1 waits until req0's last byte is accepted.
        do_reset();
        n5 = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 8'(8'hC0 + n5), 1'(n5 == 2), 1'b1, 8'hD0, 1'b0, acc);
            if (acc == 0) n5++;
            if (acc == 1) chk("lock_order", 32'(n5), 32'd3);
            if (n5 == 3) break;
        end
        drain("lock_drain");
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 40 == 0) never_busy = ($urandom_range(0, 5) == 0);
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            cycle(v0, 8'($urandom), 1'($urandom_range(0, 1)), v1, 8'($urandom), 1'($urandom_range(0, 1)), acc);
        end
        never_busy = 1'b0;
        drain("random_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter in the peripheral block between two byte sources, such as the CPU MMIO write path and a hardware event/log source. Each requester uses a valid/ready handshake. Accepted bytes go into a small FIFO in round-robin order. An issue FSM drains the FIFO into the UART TX `uart_tx_en`/`uart_tx_data`/`uart_tx_busy` interface one byte at a time.

## Interface
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, ≥2.
- `LW`, `$clog2(FIFO_DEPTH)+1`: width of `fifo_level`.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0_valid`  in  1  requester 0 has a byte.
- `req0_data`  in  8  requester 0 byte.
- `req0_last`  in  1  last byte of requester 0 burst; used only with lock feature.
- `req0_ready`  out  1  requester 0 byte accepted this cycle when valid&ready.
- `req1_valid`, `req1_data`, `req1_last`, `req1_ready`: same as requester 0, for requester 1.
- `uart_tx_busy`  in  1  transmitter busy.
- `uart_tx_en`  out  1  one-cycle launch pulse to transmitter.
- `uart_tx_data`  out  8  byte to transmit; valid while `uart_tx_en`=1.
- `fifo_level`  out  LW  occupied entries, 0..FIFO_DEPTH.
- `last_grant`  out  1  requester index of the most recently accepted byte.

## Operation
- **Acceptance**
  - At most one byte is accepted per cycle.
  - `full` = (`fifo_level`==FIFO_DEPTH), registered.
  - If `full`=1: both readies are 0.
  - Otherwise, with one valid: that requester's ready=1.
  - With both valid: ready goes to the requester not equal to priority pointer `prio`.
  - `prio` = `last_grant`, reset 1, so req0 wins the first tie.
  - Readies are combinational from valid, `full` and `prio`.
  - On accept: write data to `wr_ptr`, increment `wr_ptr` (wraps mod FIFO_DEPTH), `last_grant` <= index.
- **Issue FSM**, states IDLE, WAIT_BUSY, WAIT_DONE:
  - IDLE → WAIT_BUSY when FIFO non-empty and `uart_tx_busy`=0.
    - Next cycle: `uart_tx_en`=1, `uart_tx_data` = head byte.
    - Pop: `rd_ptr`+1, wraps.
  - WAIT_BUSY → WAIT_DONE when `uart_tx_busy`=1.
  - WAIT_BUSY → IDLE if busy not seen within 2 cycles after the pulse (timeout; byte treated as sent).
  - WAIT_DONE → IDLE when `uart_tx_busy`=0.
- **FIFO level**
  - `fifo_level` +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
  - Push while full is impossible (ready=0), even if a pop occurs the same cycle.
  - Pop while empty is impossible.
- **Reset, asynchronous, valid mid-transfer**
  - State IDLE; pointers, `fifo_level`, `uart_tx_en`, `uart_tx_data`, `last_grant` = 0; `prio` = 1.
  - FIFO contents are discarded.
  - Readies = 0 if no valid.

## Timing
- Accept → earliest `uart_tx_en`: 2 cycles.
  - Edge 1: push.
  - Edge 2: FSM leaves IDLE and registers the pulse.
- `uart_tx_en` is exactly 1 cycle wide and never asserted outside the IDLE→WAIT_BUSY transition.
- Minimum spacing between pulses: pulse, ≥1 busy cycle, 1 IDLE cycle.
- `fifo_level` reflects a push/pop on the edge it occurs.

## Configuration
- `UART_TX_ARB_LOCK_EN` defined:
  - Burst lock.
  - After accepting a byte with `reqN_last`=0, grant locks to requester N; the other requester's ready=0 even if N is idle.
  - Lock releases on the edge accepting a byte from N with `reqN_last`=1.
  - Reset clears the lock.
- Undefined:
  - `reqN_last` ignored.
  - Pure per-byte round robin as above.

## Test plan
- Single byte: `req0_valid`=1, data 0x41, busy 0.
  - → `req0_ready`=1 one cycle.
  - `uart_tx_en` pulse 2 cycles later with 0x41.
  - `fifo_level` 0→1→0.
- Contention: both valid continuously, req0 stream 0xA0.., req1 stream 0xB0..
  - → accept order A0,B0,A1,B1…
  - UART output in the same order.
- Full: busy held 1, req0 pushes 5 bytes with FIFO_DEPTH=4.
  - → 4 accepted, `req0_ready`=0 at level 4.
  - Release busy → 5th accepted after first pop.
- Busy never rises after pulse → FSM returns to IDLE after 2 cycles; next byte launches normally.
- Reset mid-transfer (level 3, WAIT_DONE) → all outputs 0, level 0, next tie grants req0.
- LOCK_EN: req0 sends 3 bytes, last on 3rd, req1 valid throughout → req1 granted only after the 3rd req0 byte is accepted.
